// File: rtl/redmule_mesh_pkg.sv
// rtl/redmule_mesh_pkg.sv - NoC AXI data channel types and outstanding-transaction limits
package redmule_mesh_pkg;

  localparam int NOC_MAX_RD_TXN = 8;
  localparam int NOC_MAX_WR_TXN = 8;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } noc_axi_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } noc_axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } noc_axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } noc_axi_r_t;

  typedef struct packed {
    noc_axi_ax_t aw;
    logic        aw_valid;
    noc_axi_w_t  w;
    logic        w_valid;
    logic        b_ready;
    noc_axi_ax_t ar;
    logic        ar_valid;
    logic        r_ready;
  } noc_axi_data_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    logic       b_valid;
    noc_axi_b_t b;
    logic       r_valid;
    noc_axi_r_t r;
  } noc_axi_data_rsp_t;

endpackage

// File: rtl/noc_txn_counter.sv
// rtl/noc_txn_counter.sv - saturating-at-zero outstanding burst counter
module noc_txn_counter #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic [Width-1:0] max,
  output logic [Width-1:0] count,
  output logic             at_max,
  output logic             underflow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + Width'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - Width'(1);
    end
  end

  assign at_max    = (count >= max);
  // A completion with nothing outstanding is a protocol error; count stays at zero.
  assign underflow = dec && !inc && (count == '0);

endmodule

// File: rtl/noc_axi_ot_limiter.sv
// rtl/noc_axi_ot_limiter.sv - caps outstanding AXI read/write bursts toward the NoC
module noc_axi_ot_limiter
  import redmule_mesh_pkg::*;
#(
  parameter int  MaxRdTxn = NOC_MAX_RD_TXN,
  parameter int  MaxWrTxn = NOC_MAX_WR_TXN,
  parameter type req_t    = redmule_mesh_pkg::noc_axi_data_req_t,
  parameter type rsp_t    = redmule_mesh_pkg::noc_axi_data_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  req_t       slv_req_i,
  output rsp_t       slv_rsp_o,
  output req_t       mst_req_o,
  input  rsp_t       mst_rsp_i,
  output logic [7:0] rd_cnt_o,
  output logic [7:0] wr_cnt_o,
  output logic       idle_o,
  output logic       err_o
);

  localparam logic [7:0] RdMax = 8'(MaxRdTxn);
  localparam logic [7:0] WrMax = 8'(MaxWrTxn);

  logic ar_hold, aw_hold;
  logic ar_open, aw_open;
  logic ar_hs, aw_hs, r_done, b_done;
  logic rd_at_max, wr_at_max, rd_uf, wr_uf;

  // A hold keeps an already-presented valid open so flush never withdraws it.
  assign ar_open = !rst_i && ((!rd_at_max && !flush_i) || ar_hold);
  assign aw_open = !rst_i && ((!wr_at_max && !flush_i) || aw_hold);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid && ar_open;
    mst_req_o.aw_valid = slv_req_i.aw_valid && aw_open;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && ar_open;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && aw_open;
  end

  assign ar_hs  = slv_req_i.ar_valid && mst_rsp_i.ar_ready && ar_open;
  assign aw_hs  = slv_req_i.aw_valid && mst_rsp_i.aw_ready && aw_open;
  assign r_done = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;
  assign b_done = mst_rsp_i.b_valid && slv_req_i.b_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_hold <= 1'b0;
      aw_hold <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      if (ar_hs) begin
        ar_hold <= 1'b0;
      end else if (slv_req_i.ar_valid && ar_open) begin
        ar_hold <= 1'b1;
      end
      if (aw_hs) begin
        aw_hold <= 1'b0;
      end else if (slv_req_i.aw_valid && aw_open) begin
        aw_hold <= 1'b1;
      end
      if (rd_uf || wr_uf) begin
        err_o <= 1'b1;
      end
    end
  end

  noc_txn_counter #(.Width(8)) u_rd_cnt (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc       (ar_hs),
    .dec       (r_done),
    .max       (RdMax),
    .count     (rd_cnt_o),
    .at_max    (rd_at_max),
    .underflow (rd_uf)
  );

  noc_txn_counter #(.Width(8)) u_wr_cnt (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc       (aw_hs),
    .dec       (b_done),
    .max       (WrMax),
    .count     (wr_cnt_o),
    .at_max    (wr_at_max),
    .underflow (wr_uf)
  );

  assign idle_o = (rd_cnt_o == 8'd0) && (wr_cnt_o == 8'd0) && !ar_hold && !aw_hold;

endmodule

// File: tb/tb_noc_axi_ot_limiter.sv
// tb/tb_noc_axi_ot_limiter.sv - directed bench for noc_axi_ot_limiter
module tb_noc_axi_ot_limiter;
  import redmule_mesh_pkg::*;

  logic clk;
  logic rst;
  logic flush;
  noc_axi_data_req_t slv_req, mst_req, mst_req_b;
  noc_axi_data_rsp_t mst_rsp, slv_rsp, slv_rsp_b;
  logic [7:0] rd_cnt, wr_cnt, rd_cnt_b, wr_cnt_b;
  logic idle, err, idle_b, err_b;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Small limits on dut; dut_b keeps defaults and sees identical stimulus.
  noc_axi_ot_limiter #(.MaxRdTxn(2), .MaxWrTxn(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .rd_cnt_o  (rd_cnt),
    .wr_cnt_o  (wr_cnt),
    .idle_o    (idle),
    .err_o     (err)
  );

  noc_axi_ot_limiter dut_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp_b),
    .mst_req_o (mst_req_b),
    .mst_rsp_i (mst_rsp),
    .rd_cnt_o  (rd_cnt_b),
    .wr_cnt_o  (wr_cnt_b),
    .idle_o    (idle_b),
    .err_o     (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    slv_req = '0;
    mst_rsp = '0;
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    tick();
    tick();
    chk("rst_mst_ar_valid", 64'(mst_req.ar_valid), 64'd0);
    chk("rst_mst_aw_valid", 64'(mst_req.aw_valid), 64'd0);
    chk("rst_slv_ar_ready", 64'(slv_rsp.ar_ready), 64'd0);
    chk("rst_slv_aw_ready", 64'(slv_rsp.aw_ready), 64'd0);
    chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_err", 64'(err), 64'd0);

    slv_req = '0;
    mst_rsp = '0;
    rst = 1'b0;
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;

    // three back-to-back ARs against a limit of two
    mst_rsp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id = 4'd1;
    slv_req.ar.addr = 32'h0000_1000;
    #1;
    chk("ar1_valid", 64'(mst_req.ar_valid), 64'd1);
    chk("ar1_addr", 64'(mst_req.ar.addr), 64'h1000);
    tick();
    slv_req.ar.id = 4'd2;
    #1;
    chk("ar2_ready", 64'(slv_rsp.ar_ready), 64'd1);
    tick();
    slv_req.ar.id = 4'd3;
    #1;
    chk("ar3_valid_blocked", 64'(mst_req.ar_valid), 64'd0);
    chk("ar3_ready_blocked", 64'(slv_rsp.ar_ready), 64'd0);
    chk("rd_cnt_at_max", 64'(rd_cnt), 64'd2);
    chk("b_ar3_ready", 64'(slv_rsp_b.ar_ready), 64'd1);
    tick();
    chk("rd_cnt_stays_max", 64'(rd_cnt), 64'd2);
    chk("b_rd_cnt_3", 64'(rd_cnt_b), 64'd3);

    // reset with three reads outstanding on dut_b
    slv_req.ar_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("b_rst_rd_cnt", 64'(rd_cnt_b), 64'd0);
    chk("b_rst_idle", 64'(idle_b), 64'd1);
    chk("b_rst_err", 64'(err_b), 64'd0);
    chk("rst_mid_rd_cnt", 64'(rd_cnt), 64'd0);

    // refill to the limit, then retire one while the third AR waits
    slv_req.ar_valid = 1'b1;
    tick();
    tick();
    chk("refill_rd_cnt", 64'(rd_cnt), 64'd2);
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last = 1'b1;
    mst_rsp.r.data = 64'hdead_beef_0123_4567;
    #1;
    chk("r_data_pass", 64'(slv_rsp.r.data), 64'hdead_beef_0123_4567);
    chk("ar3_gated_at_max", 64'(mst_req.ar_valid), 64'd0);
    tick();
    chk("rd_cnt_after_r", 64'(rd_cnt), 64'd1);
    #1;
    chk("ar3_now_open", 64'(mst_req.ar_valid), 64'd1);
    tick();
    chk("rd_cnt_inc_dec_same", 64'(rd_cnt), 64'd1);
    mst_rsp.r_valid = 1'b0;
    tick();
    chk("rd_cnt_third_passed", 64'(rd_cnt), 64'd2);
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.last = 1'b0;
    tick();
    chk("rd_cnt_non_last", 64'(rd_cnt), 64'd2);
    mst_rsp.r.last = 1'b1;
    tick();
    tick();
    mst_rsp.r_valid = 1'b0;
    chk("rd_cnt_drained", 64'(rd_cnt), 64'd0);
    chk("idle_after_reads", 64'(idle), 64'd1);

    // AW stalled by the NoC, then flush raised
    mst_rsp.ar_ready = 1'b0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr = 32'h0000_2000;
    mst_rsp.aw_ready = 1'b0;
    #1;
    chk("aw_valid_open", 64'(mst_req.aw_valid), 64'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("aw_valid_held_flush", 64'(mst_req.aw_valid), 64'd1);
    chk("idle_with_hold", 64'(idle), 64'd0);
    tick();
    chk("aw_valid_held_2", 64'(mst_req.aw_valid), 64'd1);
    mst_rsp.aw_ready = 1'b1;
    #1;
    chk("aw_ready_flush_hs", 64'(slv_rsp.aw_ready), 64'd1);
    tick();
    chk("wr_cnt_after_hs", 64'(wr_cnt), 64'd1);
    chk("aw_next_blocked", 64'(mst_req.aw_valid), 64'd0);
    chk("aw_next_ready_blocked", 64'(slv_rsp.aw_ready), 64'd0);
    slv_req.w_valid = 1'b1;
    slv_req.w.data = 64'h0bad_cafe_1234_5678;
    mst_rsp.w_ready = 1'b1;
    #1;
    chk("w_valid_flush", 64'(mst_req.w_valid), 64'd1);
    chk("w_data_pass", 64'(mst_req.w.data), 64'h0bad_cafe_1234_5678);
    chk("w_ready_pass", 64'(slv_rsp.w_ready), 64'd1);
    slv_req.w_valid = 1'b0;

    // fill writes to four, then drain four B under flush
    flush = 1'b0;
    tick();
    tick();
    tick();
    chk("wr_cnt_at_max", 64'(wr_cnt), 64'd4);
    chk("aw_blocked_at_max", 64'(mst_req.aw_valid), 64'd0);
    chk("b_aw_open_below_max", 64'(mst_req_b.aw_valid), 64'd1);
    slv_req.aw_valid = 1'b0;
    flush = 1'b1;
    mst_rsp.b_valid = 1'b1;
    mst_rsp.b.id = 4'd5;
    #1;
    chk("b_id_pass", 64'(slv_rsp.b.id), 64'd5);
    tick();
    tick();
    tick();
    tick();
    mst_rsp.b_valid = 1'b0;
    chk("wr_cnt_drained", 64'(wr_cnt), 64'd0);
    chk("idle_drained_flush", 64'(idle), 64'd1);
    chk("err_clean", 64'(err), 64'd0);

    // stray B with nothing outstanding
    mst_rsp.b_valid = 1'b1;
    tick();
    mst_rsp.b_valid = 1'b0;
    chk("wr_cnt_underflow", 64'(wr_cnt), 64'd0);
    chk("err_set", 64'(err), 64'd1);
    tick();
    tick();
    chk("err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared_rst", 64'(err), 64'd0);
    chk("idle_after_rst", 64'(idle), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
